// File: rtl/apb4_csr_bridge.sv
// -----------------------------------------------------------------------------
// apb4_csr_bridge
//   APB4 completer that turns each APB transfer into one single-beat CSR bus
//   request with a req/ack handshake. It expands PSTRB into per-bit enables,
//   holds the request while the target stalls, rejects out-of-range
//   addresses without touching the bus, and bounds the ack wait with a
//   timeout.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   s_apb_*              APB4 completer interface (pready/prdata/pslverr are
//                        derived from registers only)
//   o_bus_req*           CSR request strobe, direction, address, data, bit enables
//   i_bus_req_stall_*    target back-pressure, per direction
//   i_bus_rd_*/wr_*      CSR completion (ack, error, read data)
// -----------------------------------------------------------------------------
module apb4_csr_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LIMIT = 4096,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_apb_psel,
    input  logic                    s_apb_penable,
    input  logic                    s_apb_pwrite,
    input  logic [ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [DATA_WIDTH-1:0]   s_apb_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
    output logic                    s_apb_pready,
    output logic [DATA_WIDTH-1:0]   s_apb_prdata,
    output logic                    s_apb_pslverr,
    output logic                    o_bus_req,
    output logic                    o_bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   o_bus_addr,
    output logic [DATA_WIDTH-1:0]   o_bus_wr_data,
    output logic [DATA_WIDTH-1:0]   o_bus_wr_biten,
    input  logic                    i_bus_req_stall_wr,
    input  logic                    i_bus_req_stall_rd,
    input  logic                    i_bus_rd_ack,
    input  logic                    i_bus_rd_err,
    input  logic [DATA_WIDTH-1:0]   i_bus_rd_data,
    input  logic                    i_bus_wr_ack,
    input  logic                    i_bus_wr_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALIGN  = $clog2(STRB_W);
    localparam int CNT_W  = 16;

    // Clears the byte-lane offset bits of the captured address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << ALIGN) - 1);
    localparam logic [63:0]           LIMIT64    = 64'(ADDR_LIMIT);
    localparam logic [CNT_W-1:0]      TMO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   biten_q, biten_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    access;
    logic                    addr_ok;
    logic                    cur_stall;
    logic                    cur_ack;
    logic                    cur_err;
    logic                    tmo_hit;
    logic [DATA_WIDTH-1:0]   strb_bits;

    assign access    = s_apb_psel & s_apb_penable;
    // Widen before comparing so ADDR_LIMIT may equal 2**ADDR_WIDTH.
    assign addr_ok   = 64'(s_apb_paddr) < LIMIT64;
    // Only the handshake of the latched direction is honoured.
    assign cur_stall = is_wr_q ? i_bus_req_stall_wr : i_bus_req_stall_rd;
    assign cur_ack   = is_wr_q ? i_bus_wr_ack : i_bus_rd_ack;
    assign cur_err   = is_wr_q ? i_bus_wr_err : i_bus_rd_err;
    // Fires on the TIMEOUT-th cycle spent in REQ/WAIT without completion.
    assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        strb_bits = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_bits[8*i +: 8] = {8{s_apb_pstrb[i]}};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        biten_d = biten_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (access) begin
                    is_wr_d = s_apb_pwrite;
                    addr_d  = s_apb_paddr & ALIGN_MASK;
                    wdata_d = s_apb_pwrite ? s_apb_pwdata : '0;
                    biten_d = s_apb_pwrite ? strb_bits : '1;
                    rdata_d = '0;
                    err_d   = ~addr_ok;
                    state_d = addr_ok ? REQ : RESP;
                end
            end
            REQ, WAIT: begin
                // A stalled request is not yet accepted, so any ack seen
                // alongside the stall cannot belong to it.
                if (!(state_q == REQ && cur_stall) && cur_ack) begin
                    err_d   = cur_err;
                    rdata_d = is_wr_q ? '0 : i_bus_rd_data;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (state_q == REQ && !cur_stall) ? WAIT : state_q;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            biten_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            biten_q <= biten_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_bus_req       = (state_q == REQ);
    assign o_bus_req_is_wr = is_wr_q;
    assign o_bus_addr      = addr_q;
    assign o_bus_wr_data   = wdata_q;
    assign o_bus_wr_biten  = biten_q;

    // Response fields are forced to zero outside the single RESP cycle.
    assign s_apb_pready  = (state_q == RESP);
    assign s_apb_prdata  = s_apb_pready ? rdata_q : '0;
    assign s_apb_pslverr = s_apb_pready & err_q;

endmodule

// File: tb/tb_apb4_csr_bridge.sv
module tb_apb4_csr_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        req, req_is_wr;
    logic [15:0] baddr;
    logic [31:0] bwdata, bbiten;
    logic        stall_wr, stall_rd;
    logic        rd_ack, rd_err, wr_ack, wr_err;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb4_csr_bridge #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .ADDR_LIMIT(4096), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
        .o_bus_req(req), .o_bus_req_is_wr(req_is_wr), .o_bus_addr(baddr),
        .o_bus_wr_data(bwdata), .o_bus_wr_biten(bbiten),
        .i_bus_req_stall_wr(stall_wr), .i_bus_req_stall_rd(stall_rd),
        .i_bus_rd_ack(rd_ack), .i_bus_rd_err(rd_err), .i_bus_rd_data(rd_data),
        .i_bus_wr_ack(wr_ack), .i_bus_wr_err(wr_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Setup phase, then access phase; returns one cycle after the DUT
    // sampled psel&penable (cycle N+1).
    task automatic apb_start(input logic wr, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        tick();
        penable = 1'b1;
        tick();
    endtask

    task automatic apb_end();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL reset pready: got %b want 0", pready); end
        n_tests++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset prdata: got %h want 0", prdata); end
        n_tests++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset pslverr: got %b want 0", pslverr); end
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset req: got %b want 0", req); end
        n_tests++; if ({req_is_wr, baddr, bwdata, bbiten} !== 81'h0) begin n_fail++;
            $display("FAIL reset bus: got %b %h %h %h want all 0", req_is_wr, baddr, bwdata, bbiten); end
    endtask

    task automatic test_write();
        apb_start(1'b1, 16'h010, 32'h0000_00A5, 4'b0001);
        wr_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (req !== 1'b1 || req_is_wr !== 1'b1) begin n_fail++; $display("FAIL wr req: got %b/%b want 1/1", req, req_is_wr); end
        n_tests++; if (baddr !== 16'h010) begin n_fail++; $display("FAIL wr addr: got %h want 0010", baddr); end
        n_tests++; if (bbiten !== 32'h0000_00FF) begin n_fail++; $display("FAIL wr biten: got %h want 000000ff", bbiten); end
        n_tests++; if (bwdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL wr data: got %h want 000000a5", bwdata); end
        n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL wr pready N+1: got %b want 0", pready); end
        tick(); wr_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b0 || prdata !== 32'h0) begin n_fail++;
            $display("FAIL wr resp N+2: got rdy=%b err=%b rd=%h want 1 0 0", pready, pslverr, prdata); end
        apb_end(); tick();
        @(negedge clk);
        n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL wr pready one cycle: got %b want 0", pready); end
    endtask

    task automatic test_read_wait();
        apb_start(1'b0, 16'h020, 32'h0, 4'h0);
        @(negedge clk);
        n_tests++; if (req !== 1'b1 || req_is_wr !== 1'b0) begin n_fail++; $display("FAIL rd req: got %b/%b want 1/0", req, req_is_wr); end
        n_tests++; if (bbiten !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rd biten: got %h want ffffffff", bbiten); end
        tick(); wr_ack = 1'b1;      // N+2: wrong-direction ack must be ignored
        @(negedge clk);
        n_tests++; if (req !== 1'b0 || pready !== 1'b0) begin n_fail++; $display("FAIL rd wait N+2: got req=%b rdy=%b want 0 0", req, pready); end
        tick(); wr_ack = 1'b0;      // N+3
        @(negedge clk);
        n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rd wait N+3: got %b want 0", pready); end
        tick(); rd_ack = 1'b1; rd_data = 32'hDEAD_BEEF;   // N+4, also the last counted cycle
        @(negedge clk);
        n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rd wait N+4: got %b want 0", pready); end
        tick(); rd_ack = 1'b0; rd_data = 32'h0;           // N+5
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || prdata !== 32'hDEAD_BEEF || pslverr !== 1'b0) begin n_fail++;
            $display("FAIL rd resp N+5: got rdy=%b rd=%h err=%b want 1 deadbeef 0", pready, prdata, pslverr); end
        apb_end(); tick();
        @(negedge clk);
        n_tests++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL rd prdata idle: got %h want 0", prdata); end
    endtask

    task automatic test_rd_err();
        apb_start(1'b0, 16'h044, 32'h0, 4'h0);
        rd_ack = 1'b1; rd_err = 1'b1; rd_data = 32'h1234_5678;
        tick(); rd_ack = 1'b0; rd_err = 1'b0; rd_data = 32'h0;
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== 32'h1234_5678) begin n_fail++;
            $display("FAIL rderr resp: got rdy=%b err=%b rd=%h want 1 1 12345678", pready, pslverr, prdata); end
        apb_end(); tick();
    endtask

    task automatic test_addr_range();
        apb_start(1'b0, 16'h1000, 32'h0, 4'h0);
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b1) begin n_fail++; $display("FAIL illegal resp N+1: got rdy=%b err=%b want 1 1", pready, pslverr); end
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL illegal req: got %b want 0", req); end
        apb_end(); tick();
        @(negedge clk);
        n_tests++; if (req !== 1'b0 || pready !== 1'b0) begin n_fail++; $display("FAIL illegal after: got req=%b rdy=%b want 0 0", req, pready); end
        tick();
        // Last legal byte: request issued with address aligned down to the word.
        apb_start(1'b0, 16'h0FFF, 32'h0, 4'h0);
        rd_ack = 1'b1; rd_data = 32'h0000_0055;
        @(negedge clk);
        n_tests++; if (req !== 1'b1 || baddr !== 16'h0FFC) begin n_fail++; $display("FAIL edge addr: got req=%b addr=%h want 1 0ffc", req, baddr); end
        tick(); rd_ack = 1'b0; rd_data = 32'h0;
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b0 || prdata !== 32'h55) begin n_fail++;
            $display("FAIL edge resp: got rdy=%b err=%b rd=%h want 1 0 00000055", pready, pslverr, prdata); end
        apb_end(); tick();
    endtask

    task automatic test_timeout();
        apb_start(1'b1, 16'h030, 32'h1, 4'hF);
        @(negedge clk);
        n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL tmo req: got %b want 1", req); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clk);
            n_tests++; if (pready !== 1'b0) begin n_fail++; $display("FAIL tmo early N+%0d: got %b want 0", k, pready); end
        end
        tick();
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== 32'h0) begin n_fail++;
            $display("FAIL tmo resp N+5: got rdy=%b err=%b rd=%h want 1 1 0", pready, pslverr, prdata); end
        apb_end(); tick(); wr_ack = 1'b1;   // late ack while idle
        @(negedge clk);
        n_tests++; if (pready !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL tmo late ack: got rdy=%b req=%b want 0 0", pready, req); end
        tick(); wr_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (pready !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL tmo late ack+1: got rdy=%b req=%b want 0 0", pready, req); end
    endtask

    task automatic test_stall();
        int reqs = 0;
        apb_start(1'b1, 16'h040, 32'hCAFE_F00D, 4'hF);
        stall_wr = 1'b1;
        @(negedge clk); reqs += int'(req);
        tick();
        @(negedge clk); reqs += int'(req);
        tick(); stall_wr = 1'b0; wr_ack = 1'b1;
        @(negedge clk); reqs += int'(req);
        tick(); wr_ack = 1'b0;
        @(negedge clk); reqs += int'(req);
        n_tests++; if (reqs != 3) begin n_fail++; $display("FAIL stall req cycles: got %0d want 3", reqs); end
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b0) begin n_fail++; $display("FAIL stall resp N+4: got rdy=%b err=%b want 1 0", pready, pslverr); end
        apb_end(); tick();
        // Read-side stall must not hold a write.
        stall_rd = 1'b1;
        apb_start(1'b1, 16'h060, 32'h0000_0077, 4'b1100);
        wr_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (req !== 1'b1 || bbiten !== 32'hFFFF_0000) begin n_fail++; $display("FAIL rdstall req: got req=%b biten=%h want 1 ffff0000", req, bbiten); end
        tick(); wr_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (pready !== 1'b1) begin n_fail++; $display("FAIL rdstall resp N+2: got %b want 1", pready); end
        apb_end(); stall_rd = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        apb_start(1'b0, 16'h050, 32'h0, 4'h0);
        tick();                      // now in WAIT
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({req, req_is_wr, pready, pslverr} !== 4'b0 || baddr !== 16'h0 || bbiten !== 32'h0 || prdata !== 32'h0) begin
            n_fail++; $display("FAIL midrst outputs: got req=%b wr=%b rdy=%b addr=%h biten=%h want all 0", req, req_is_wr, pready, baddr, bbiten); end
        rd_ack = 1'b1; rd_data = 32'h1111_1111;
        tick(); apb_end(); rd_ack = 1'b0; rd_data = 32'h0;
        tick(); rst = 1'b0;
        tick();
        @(negedge clk);
        n_tests++; if (pready !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL midrst idle: got rdy=%b req=%b want 0 0", pready, req); end
        tick();
        apb_start(1'b1, 16'h070, 32'h0000_0099, 4'b0010);
        wr_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (req !== 1'b1 || baddr !== 16'h070 || bbiten !== 32'h0000_FF00) begin n_fail++;
            $display("FAIL midrst next req: got req=%b addr=%h biten=%h want 1 0070 0000ff00", req, baddr, bbiten); end
        tick(); wr_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (pready !== 1'b1 || pslverr !== 1'b0) begin n_fail++; $display("FAIL midrst next resp: got rdy=%b err=%b want 1 0", pready, pslverr); end
        apb_end(); tick();
    endtask

    initial begin
        rst = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
        stall_wr = 0; stall_rd = 0; rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0; rd_data = '0;
        repeat (3) @(posedge clk);
        test_reset();
        rst = 1'b0;
        tick();
        test_write();
        test_read_wait();
        test_rd_err();
        test_addr_range();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
